// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the two-port stack arbiter.
// Holds the controller state encoding and the push/pop opcode values.
package stack_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE,
        ACK,
        FLUSH
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection. Purely combinational.
// The priority pointer register lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    // NOTE: every output is given a value on every path so no latch is inferred.
    always_comb begin
        gnt_valid = |req;
        if (&req) begin
            gnt_idx = ptr;
        end else begin
            gnt_idx = req[1];
        end
    end

endmodule

// File: rtl/stack_port_arbiter.sv
// Shares one push/pop stack between two requesters through a four-state
// issue/settle/ack sequence, with overflow/underflow guarding and flush.
module stack_port_arbiter
    import stack_arb_pkg::*;
#(
    parameter int N = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] op,
    input  logic [N:0] wdata0,
    input  logic [N:0] wdata1,
    input  logic       flush,
    output logic [1:0] ack,
    output logic       err,
    output logic [N:0] rdata,
    output logic       flush_ack,
    output logic       stk_en,
    output logic       stk_pushpop,
    output logic       stk_clr,
    output logic [N:0] stk_din,
    input  logic [N:0] stk_dout,
    input  logic       stk_empty,
    input  logic       stk_full
);

    state_t     state;
    logic       sel;
    logic       ptr;
    logic       err_r;
    logic       clr_r;
    logic [N:0] rdata_r;

    logic       gnt_idx;
    logic       gnt_valid;
    logic       op_g;
    logic [N:0] wdata_g;
    logic       legal;

    rr_arb2 u_rr_arb2 (
        .req       (req),
        .ptr       (ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // The stack is idle between IDLE and ISSUE, so the flags seen here are
    // the same ones that stand during the ISSUE cycle.
    always_comb begin
        op_g    = op[gnt_idx];
        wdata_g = gnt_idx ? wdata1 : wdata0;
        legal   = (op_g == OP_PUSH) ? !stk_full : !stk_empty;
    end

    // Stack reset follows the controller reset immediately, not a cycle late.
    assign stk_clr = clr_r | ~reset;
    assign rdata   = rdata_r;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            sel         <= 1'b0;
            ptr         <= 1'b0;
            err_r       <= 1'b0;
            clr_r       <= 1'b0;
            rdata_r     <= '0;
            ack         <= 2'b00;
            err         <= 1'b0;
            flush_ack   <= 1'b0;
            stk_en      <= 1'b0;
            stk_pushpop <= 1'b0;
            stk_din     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        state     <= FLUSH;
                        clr_r     <= 1'b1;
                        flush_ack <= 1'b1;
                    end else if (gnt_valid) begin
                        state       <= ISSUE;
                        sel         <= gnt_idx;
                        ptr         <= ~gnt_idx;
                        stk_pushpop <= op_g;
                        stk_din     <= wdata_g;
                        stk_en      <= legal;
                        err_r       <= ~legal;
                    end
                end
                ISSUE: begin
                    stk_en <= 1'b0;
                    // Top of stack is captured before the pop shifts it away.
                    if (stk_en && stk_pushpop == OP_POP) begin
                        rdata_r <= stk_dout;
                    end
                    state <= SETTLE;
                end
                SETTLE: begin
                    ack   <= sel ? 2'b10 : 2'b01;
                    err   <= err_r;
                    state <= ACK;
                end
                ACK: begin
                    ack   <= 2'b00;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                FLUSH: begin
                    clr_r     <= 1'b0;
                    flush_ack <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
